// File: rtl/scalable_pkg.sv
// Shared defaults and state encoding for the scalable compute array feeder and result path.
package scalable_pkg;

  localparam int unsigned DEFAULT_CORE_COUNT   = 4;
  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 16;
  localparam int unsigned DEFAULT_RESULT_WIDTH = 32;
  localparam int unsigned DEFAULT_COUNT_WIDTH  = 16;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } dist_state_t;

endpackage

// File: rtl/lane_vector_reg.sv
// Output vector register: holds a loaded vector stable until the array takes it, and counts
// completed hand-offs.
module lane_vector_reg #(
  parameter int unsigned CORE_COUNT   = scalable_pkg::DEFAULT_CORE_COUNT,
  parameter int unsigned SAMPLE_WIDTH = scalable_pkg::DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned COUNT_WIDTH  = scalable_pkg::DEFAULT_COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               loadEn_i,
  input  logic [CORE_COUNT*SAMPLE_WIDTH-1:0] loadSamples_i,
  input  logic [CORE_COUNT-1:0]              loadMask_i,
  input  logic                               loadLast_i,
  input  logic                               outReady_i,
  output logic                               outFree_o,
  output logic                               outValid_o,
  output logic [CORE_COUNT*SAMPLE_WIDTH-1:0] outSamples_o,
  output logic [CORE_COUNT-1:0]              outMask_o,
  output logic                               outLast_o,
  output logic [COUNT_WIDTH-1:0]             vectorCount_o
);

  logic                               validQ;
  logic [CORE_COUNT*SAMPLE_WIDTH-1:0] samplesQ;
  logic [CORE_COUNT-1:0]              maskQ;
  logic                               lastQ;
  logic [COUNT_WIDTH-1:0]             countQ;

  assign outFree_o = !validQ || outReady_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      validQ   <= 1'b0;
      samplesQ <= '0;
      maskQ    <= '0;
      lastQ    <= 1'b0;
      countQ   <= '0;
    end else begin
      // A load in the same cycle as a hand-off keeps the register full back-to-back.
      if (loadEn_i) begin
        validQ   <= 1'b1;
        samplesQ <= loadSamples_i;
        maskQ    <= loadMask_i;
        lastQ    <= loadLast_i;
      end else if (outReady_i) begin
        validQ <= 1'b0;
      end
      if (validQ && outReady_i) begin
        countQ <= countQ + COUNT_WIDTH'(1);
      end
    end
  end

  assign outValid_o    = validQ;
  assign outSamples_o  = samplesQ;
  assign outMask_o     = maskQ;
  assign outLast_o     = lastQ;
  assign vectorCount_o = countQ;

endmodule

// File: rtl/sample_lane_distributor.sv
// Deals a serial sample stream round-robin into CORE_COUNT lanes and emits one parallel vector
// per full set of lanes or per frame end.
module sample_lane_distributor
  import scalable_pkg::*;
#(
  parameter int unsigned CORE_COUNT   = DEFAULT_CORE_COUNT,
  parameter int unsigned SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SAMPLE_WIDTH-1:0]            in_sample,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CORE_COUNT*SAMPLE_WIDTH-1:0] out_samples,
  output logic [CORE_COUNT-1:0]              out_lane_mask,
  output logic                               out_last,
  output logic [COUNT_WIDTH-1:0]             vector_count
);

  localparam int unsigned LaneW = $clog2(CORE_COUNT);
  localparam int unsigned VecW  = CORE_COUNT * SAMPLE_WIDTH;

  dist_state_t          stateQ, stateD;
  logic [VecW-1:0]       collectQ, collectD;
  logic [CORE_COUNT-1:0] maskQ, maskD;
  logic [LaneW-1:0]      laneIdxQ, laneIdxD;
  logic                  holdLastQ, holdLastD;

  logic [VecW-1:0]       mergedSamples;
  logic [CORE_COUNT-1:0] mergedMask;
  logic                  accept;
  logic                  complete;
  logic                  outFree;
  logic                  loadEn;
  logic [VecW-1:0]       loadSamples;
  logic [CORE_COUNT-1:0] loadMask;
  logic                  loadLast;

  assign in_ready = reset && (stateQ == FILL);
  assign accept   = in_valid && in_ready;
  assign complete = (laneIdxQ == LaneW'(CORE_COUNT - 1)) || in_last;

  // Collect contents with the incoming sample already written into its lane.
  always_comb begin
    mergedSamples = collectQ;
    mergedMask    = maskQ;
    mergedSamples[laneIdxQ*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_sample;
    mergedMask[laneIdxQ] = 1'b1;
  end

  always_comb begin
    stateD      = stateQ;
    collectD    = collectQ;
    maskD       = maskQ;
    laneIdxD    = laneIdxQ;
    holdLastD   = holdLastQ;
    loadEn      = 1'b0;
    loadSamples = mergedSamples;
    loadMask    = mergedMask;
    loadLast    = in_last;
    unique case (stateQ)
      FILL: begin
        if (accept) begin
          if (!complete) begin
            collectD = mergedSamples;
            maskD    = mergedMask;
            laneIdxD = laneIdxQ + LaneW'(1);
          end else if (outFree) begin
            loadEn   = 1'b1;
            collectD = '0;
            maskD    = '0;
            laneIdxD = '0;
          end else begin
            collectD  = mergedSamples;
            maskD     = mergedMask;
            holdLastD = in_last;
            stateD    = HOLD;
          end
        end
      end
      HOLD: begin
        loadSamples = collectQ;
        loadMask    = maskQ;
        loadLast    = holdLastQ;
        if (outFree) begin
          loadEn   = 1'b1;
          collectD = '0;
          maskD    = '0;
          laneIdxD = '0;
          stateD   = FILL;
        end
      end
      default: stateD = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ    <= FILL;
      collectQ  <= '0;
      maskQ     <= '0;
      laneIdxQ  <= '0;
      holdLastQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      collectQ  <= collectD;
      maskQ     <= maskD;
      laneIdxQ  <= laneIdxD;
      holdLastQ <= holdLastD;
    end
  end

  lane_vector_reg #(
    .CORE_COUNT  (CORE_COUNT),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_lane_vector_reg (
    .clk          (clk),
    .reset        (reset),
    .loadEn_i     (loadEn),
    .loadSamples_i(loadSamples),
    .loadMask_i   (loadMask),
    .loadLast_i   (loadLast),
    .outReady_i   (out_ready),
    .outFree_o    (outFree),
    .outValid_o   (out_valid),
    .outSamples_o (out_samples),
    .outMask_o    (out_lane_mask),
    .outLast_o    (out_last),
    .vectorCount_o(vector_count)
  );

endmodule

// File: tb/tb_sample_lane_distributor.sv
// Randomized bench for sample_lane_distributor against a frame-level queue model.
module tb_sample_lane_distributor;

  localparam int unsigned CC = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sample;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [CC*SW-1:0] out_samples;
  logic [CC-1:0]   out_lane_mask;
  logic            out_last;
  logic [CW-1:0]   vector_count;

  always #5 clk = ~clk;

  sample_lane_distributor #(
    .CORE_COUNT  (CC),
    .SAMPLE_WIDTH(SW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sample    (in_sample),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_samples  (out_samples),
    .out_lane_mask(out_lane_mask),
    .out_last     (out_last),
    .vector_count (vector_count)
  );

  typedef struct packed {
    logic [CC*SW-1:0] samples;
    logic [CC-1:0]    mask;
    logic             last;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Model: vectors completed but not yet handed off, plus the frame being gathered.
  vec_t             expQ[$];
  logic [CC*SW-1:0] frameData = '0;
  int               frameLen = 0;
  logic [CW-1:0]    modelCount = '0;

  logic             stallPrev = 1'b0;
  vec_t             prevVec;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    expQ.delete();
    frameData  = '0;
    frameLen   = 0;
    modelCount = '0;
    stallPrev  = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, then cross the edge.
  task automatic step(input logic vld, input logic [SW-1:0] smp, input logic lst,
                      input logic ordy, output logic acc);
    vec_t v;
    in_valid  = vld;
    in_sample = smp;
    in_last   = lst;
    out_ready = ordy;
    #1;
    checkVal("in_ready", in_ready, expQ.size() < 2);
    checkVal("out_valid", out_valid, expQ.size() != 0);
    checkVal("vector_count", vector_count, modelCount);
    if (stallPrev && out_valid) begin
      checkVal("stable_samples", out_samples, prevVec.samples);
      checkVal("stable_mask", out_lane_mask, prevVec.mask);
      checkVal("stable_last", out_last, prevVec.last);
    end
    stallPrev = out_valid && !ordy;
    prevVec   = '{samples: out_samples, mask: out_lane_mask, last: out_last};
    if (out_valid && ordy && expQ.size() != 0) begin
      v = expQ.pop_front();
      checkVal("out_samples", out_samples, v.samples);
      checkVal("out_lane_mask", out_lane_mask, v.mask);
      checkVal("out_last", out_last, v.last);
      modelCount = modelCount + 1'b1;
    end
    acc = vld && in_ready;
    if (acc) begin
      frameData[frameLen*SW +: SW] = smp;
      frameLen++;
      if (frameLen == CC || lst) begin
        expQ.push_back('{samples: frameData, mask: CC'((1 << frameLen) - 1), last: lst});
        frameData = '0;
        frameLen  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Source holds each sample until accepted; returns samples sent and cycles used.
  task automatic stream(input logic [SW-1:0] vals[$], input int lastIdx, input logic ordy,
                        input int budget, output int sent, output int cycles);
    logic acc;
    sent   = 0;
    cycles = 0;
    while (sent < vals.size() && cycles < budget) begin
      step(1'b1, vals[sent], sent == lastIdx, ordy, acc);
      if (acc) sent++;
      cycles++;
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      step(1'b0, SW'($urandom), 1'b0, 1'b1, acc);
    end
    step(1'b0, '0, 1'b0, 1'b1, acc);
    checkVal("drained", expQ.size(), 0);
  endtask

  task automatic doReset(input int n);
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_sample = SW'($urandom);
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkVal("rst_in_ready", in_ready, 0);
      checkVal("rst_out_valid", out_valid, 0);
      checkVal("rst_samples", out_samples, 0);
      checkVal("rst_mask", out_lane_mask, 0);
      checkVal("rst_last", out_last, 0);
      checkVal("rst_count", vector_count, 0);
    end
    modelClear();
    in_valid = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] vals[$];
    int sent, cycles;

    // Reset with a pending input
    doReset(3);

    // Full vector 1..4
    vals = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    stream(vals, -1, 1'b1, 10, sent, cycles);
    checkVal("full_sent", sent, 4);
    checkVal("full_vec", out_samples, 64'h0004_0003_0002_0001);
    drain();

    // Partial frame, then a full vector that must start in lane 0
    vals = '{16'hAAAA, 16'hBBBB};
    stream(vals, 1, 1'b1, 10, sent, cycles);
    checkVal("part_mask", out_lane_mask, 4'b0011);
    vals = '{SW'($urandom), SW'($urandom), SW'($urandom), SW'($urandom)};
    stream(vals, -1, 1'b1, 10, sent, cycles);
    drain();

    // 1-lane frame
    vals = '{SW'($urandom)};
    stream(vals, 0, 1'b1, 10, sent, cycles);
    checkVal("one_lane_mask", out_lane_mask, 4'b0001);
    drain();

    // Backpressure: 9 samples with the array stalled
    vals.delete();
    for (int i = 0; i < 9; i++) vals.push_back(SW'($urandom));
    stream(vals, -1, 1'b0, 20, sent, cycles);
    checkVal("bp_stalled_at", sent, 8);
    vals = vals[sent:$];
    stream(vals, -1, 1'b1, 20, sent, cycles);
    checkVal("bp_rest_sent", sent, 1);
    drain();

    // Throughput: 400 samples, random frame ends disabled, one per cycle
    vals.delete();
    for (int i = 0; i < 400; i++) vals.push_back(SW'($urandom));
    stream(vals, -1, 1'b1, 800, sent, cycles);
    checkVal("tput_sent", sent, 400);
    checkVal("tput_cycles", cycles, 400);
    drain();

    // Random traffic with random frame ends and random backpressure
    for (int i = 0; i < 300; i++) begin
      logic acc;
      step(1'($urandom_range(0, 3) != 0), SW'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    // Reset mid-frame discards the partial collect
    vals = '{SW'($urandom), SW'($urandom)};
    stream(vals, -1, 1'b1, 10, sent, cycles);
    doReset(1);
    vals = '{SW'($urandom), SW'($urandom), SW'($urandom), SW'($urandom)};
    stream(vals, -1, 1'b1, 10, sent, cycles);
    checkVal("post_rst_lane0", out_samples[SW-1:0], vals[0]);
    drain();
    checkVal("post_rst_count", vector_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
